// File: rtl/uart_pkg.sv
// uart_pkg: shared UART rate constants and FSM state encoding
package uart_pkg;
  localparam int CLK = 28000000;
  localparam int CLKDS80 = 24000000;
  localparam int BPS = 115200;
  localparam int PERIOD = CLK / BPS;
  localparam int PERIODDS80 = CLKDS80 / BPS;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous DEPTH x 8 FIFO with combinational head and occupancy count
module uart_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_bus,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign do_wr = wr && (!full || rd);
  assign do_rd = rd && !empty;
  assign dout = mem[rp];
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  // pointers and occupancy; a write into a full FIFO succeeds only alongside a pop
  always_ff @(posedge clk_bus) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
  // storage
  always_ff @(posedge clk_bus) begin
    if (do_wr) mem[wp] <= din;
  end
endmodule

// File: rtl/uart_tx_flow.sv
// uart_tx_flow: FIFO-buffered 8N1 transmitter with cts flow control and dual clock-rate timing
module uart_tx_flow #(
  parameter int CLK = uart_pkg::CLK,
  parameter int CLKDS80 = uart_pkg::CLKDS80,
  parameter int BPS = uart_pkg::BPS,
  parameter int DEPTH = 16
) (
  input  logic                   clk_bus,
  input  logic                   reset,
  input  logic                   ds80,
  input  logic [7:0]             txdata,
  input  logic                   wr,
  input  logic                   cts,
  output logic                   tx,
  output logic                   txbusy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  import uart_pkg::*;
  localparam logic [7:0] PER_N = 8'(CLK / BPS);
  localparam logic [7:0] PER_D = 8'(CLKDS80 / BPS);
  state_t state;
  logic cts_m, cts_s, pop;
  logic [7:0] head, sh, per, cnt, per_sel;
  logic [2:0] bitn;
  assign per_sel = ds80 ? PER_D : PER_N;
  assign pop = !empty && !cts_s && (state == IDLE || (state == STOP && cnt == '0));
  uart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_bus(clk_bus), .reset(reset), .wr(wr), .rd(pop), .din(txdata),
    .dout(head), .level(level), .full(full), .empty(empty)
  );
  // two-flop synchronizer for the asynchronous peer busy line
  always_ff @(posedge clk_bus) begin
    if (reset) {cts_s, cts_m} <= 2'b00;
    else {cts_s, cts_m} <= {cts_m, cts};
  end
  // sticky flag for writes dropped against a full FIFO with no pop to make room
  always_ff @(posedge clk_bus) begin
    if (reset) overflow <= 1'b0;
    else if (wr && full && !pop) overflow <= 1'b1;
  end
  // frame FSM: a pop starts a frame and freezes its bit period until the frame ends
  always_ff @(posedge clk_bus) begin
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      txbusy <= 1'b0;
      sh <= '0;
      per <= PER_N;
      cnt <= '0;
      bitn <= '0;
    end else if (pop) begin
      state <= START;
      tx <= 1'b0;
      txbusy <= 1'b1;
      sh <= head;
      per <= per_sel;
      cnt <= per_sel - 8'd1;
      bitn <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt == '0 ? per - 8'd1 : cnt - 8'd1;
      if (cnt == '0) begin
        case (state)
          START: begin
            state <= DATA;
            tx <= sh[0];
          end
          DATA: begin
            sh <= sh >> 1;
            bitn <= bitn + 3'd1;
            state <= bitn == 3'd7 ? STOP : DATA;
            tx <= bitn == 3'd7 ? 1'b1 : sh[1];
          end
          default: begin
            state <= IDLE;
            txbusy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_flow.sv
// tb_uart_tx_flow: directed table and frame-sequence checks for uart_tx_flow
module tb_uart_tx_flow;
  logic clk_bus = 1'b0;
  logic reset = 1'b1, ds80 = 1'b0, wr = 1'b0, cts = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic tx, txbusy, full, empty, overflow;
  logic [4:0] level;
  int checks = 0, errors = 0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic [4:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       tx;
  } vec_t;
  vec_t tv [18];

  uart_tx_flow dut (
    .clk_bus(clk_bus), .reset(reset), .ds80(ds80), .txdata(txdata), .wr(wr), .cts(cts),
    .tx(tx), .txbusy(txbusy), .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk_bus = ~clk_bus;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr = 1'b1;
    txdata = b;
    @(negedge clk_bus);
    wr = 1'b0;
  endtask

  task automatic wait_fall(output int n, input int budget);
    n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk_bus);
      n++;
    end
    if (tx !== 1'b0) chk("start bit timeout", 32'(tx), 32'd0);
  endtask

  task automatic check_frame(input logic [7:0] b, input int p, input int act, input string nm);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < p; j++) begin
        if (i != 0 || j != 0) @(negedge clk_bus);
        if (i == 3 && j == 0 && act == 1) ds80 = ~ds80;
        if (i == 3 && j == 0 && act == 2) cts = 1'b1;
        if (j == 0 || j == p - 1) begin
          chk($sformatf("%s bit%0d off%0d tx", nm, i, j), 32'(tx), 32'(f[i]));
          chk($sformatf("%s bit%0d off%0d txbusy", nm, i, j), 32'(txbusy), 32'd1);
        end
      end
  endtask

  initial begin
    int n, z;
    for (int i = 0; i < 17; i++)
      tv[i] = '{1'b1, 8'(i), (i < 16) ? 5'(i + 1) : 5'd16, i >= 15, 1'b0, i == 16, 1'b1};
    tv[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(negedge clk_bus);
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst txbusy", 32'(txbusy), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_bus);

    ds80 = 1'b0;
    wr_byte(8'h55);
    wait_fall(n, 100);
    chk("0x55 latency", 32'(n), 32'd1);
    check_frame(8'h55, 243, 1, "f55");
    @(negedge clk_bus);
    chk("0x55 idle tx", 32'(tx), 32'd1);
    chk("0x55 idle txbusy", 32'(txbusy), 32'd0);

    ds80 = 1'b1;
    wr_byte(8'hA3);
    wr_byte(8'h0F);
    wait_fall(n, 100);
    chk("A3 latency", 32'(n), 32'd0);
    check_frame(8'hA3, 208, 0, "fA3");
    @(negedge clk_bus);
    check_frame(8'h0F, 208, 0, "f0F");
    @(negedge clk_bus);
    chk("0F idle tx", 32'(tx), 32'd1);
    chk("0F idle empty", 32'(empty), 32'd1);

    ds80 = 1'b0;
    cts = 1'b1;
    repeat (4) @(negedge clk_bus);
    wr_byte(8'h41);
    repeat (20) @(negedge clk_bus);
    chk("cts hold tx", 32'(tx), 32'd1);
    chk("cts hold level", 32'(level), 32'd1);
    cts = 1'b0;
    wait_fall(n, 100);
    chk("cts release latency", 32'(n), 32'd3);
    check_frame(8'h41, 243, 0, "f41");
    @(negedge clk_bus);

    cts = 1'b1;
    repeat (4) @(negedge clk_bus);
    for (int i = 0; i < 18; i++) begin
      wr = tv[i].wr;
      txdata = tv[i].d;
      @(negedge clk_bus);
      chk($sformatf("tv%0d level", i), 32'(level), 32'(tv[i].lvl));
      chk($sformatf("tv%0d full", i), 32'(full), 32'(tv[i].full));
      chk($sformatf("tv%0d empty", i), 32'(empty), 32'(tv[i].empty));
      chk($sformatf("tv%0d overflow", i), 32'(overflow), 32'(tv[i].ovf));
      chk($sformatf("tv%0d tx", i), 32'(tx), 32'(tv[i].tx));
    end
    wr = 1'b0;
    cts = 1'b0;
    wait_fall(n, 100);
    chk("burst release latency", 32'(n), 32'd3);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk_bus);
      check_frame(8'(k), 243, 0, $sformatf("burst%0d", k));
    end
    @(negedge clk_bus);
    chk("burst end tx", 32'(tx), 32'd1);
    chk("burst end txbusy", 32'(txbusy), 32'd0);
    chk("burst end empty", 32'(empty), 32'd1);
    chk("burst overflow sticky", 32'(overflow), 32'd1);

    reset = 1'b1;
    @(negedge clk_bus);
    reset = 1'b0;
    chk("reset clears overflow", 32'(overflow), 32'd0);
    wr_byte(8'h11);
    wr_byte(8'h22);
    wait_fall(n, 100);
    check_frame(8'h11, 243, 2, "f11");
    z = 0;
    repeat (60) begin
      @(negedge clk_bus);
      if (tx !== 1'b1) z++;
    end
    chk("0x22 held tx", 32'(z), 32'd0);
    chk("0x22 held level", 32'(level), 32'd1);
    chk("0x22 held txbusy", 32'(txbusy), 32'd0);
    cts = 1'b0;
    wait_fall(n, 100);
    chk("0x22 release latency", 32'(n), 32'd3);
    check_frame(8'h22, 243, 0, "f22");
    @(negedge clk_bus);

    wr_byte(8'h7E);
    wait_fall(n, 100);
    repeat (4 * 243 + 100) @(negedge clk_bus);
    chk("7E mid-frame tx", 32'(tx), 32'd1);
    reset = 1'b1;
    wr = 1'b1;
    txdata = 8'h99;
    @(negedge clk_bus);
    reset = 1'b0;
    wr = 1'b0;
    chk("mid reset tx", 32'(tx), 32'd1);
    chk("mid reset txbusy", 32'(txbusy), 32'd0);
    chk("mid reset level", 32'(level), 32'd0);
    chk("mid reset empty", 32'(empty), 32'd1);
    z = 0;
    repeat (2600) begin
      @(negedge clk_bus);
      if (tx !== 1'b1) z++;
    end
    chk("no start after reset", 32'(z), 32'd0);
    chk("level after reset idle", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_flow.md
UART_TX_FLOW -- requirements
Module: uart_tx_flow

Interface
REQ-001 Parameter CLK, default 28000000: clk_bus frequency in Hz when ds80=0.
REQ-002 Parameter CLKDS80, default 24000000: clk_bus frequency in Hz when ds80=1.
REQ-003 Parameter BPS, default 115200: line rate; PERIOD=CLK/BPS (243), PERIODDS80=CLKDS80/BPS (208).
REQ-004 Parameter DEPTH, default 16: FIFO entries, power of two.
REQ-005 clk_bus  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ds80  input  1  clock-rate select; 1 selects PERIODDS80, 0 selects PERIOD.
REQ-008 txdata  input  8  byte to enqueue.
REQ-009 wr  input  1  one-cycle write strobe; enqueues txdata.
REQ-010 cts  input  1  peer busy (driven by peer rts); 1 = hold off new frames; asynchronous.
REQ-011 tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-012 txbusy  output  1  high while a frame is on the line.
REQ-013 full  output  1  FIFO holds DEPTH bytes.
REQ-014 empty  output  1  FIFO holds 0 bytes.
REQ-015 level  output  5  FIFO occupancy, 0..DEPTH.
REQ-016 overflow  output  1  sticky; set when a write is dropped.

Function
REQ-017 cts SHALL pass through a 2-FF synchronizer (cts_s) before use.
REQ-018 Write with full=0, or with full=1 and a pop in the same cycle, SHALL be accepted; write with full=1 and no pop SHALL be dropped and set overflow.
REQ-019 level/full/empty SHALL update the cycle after the write/pop; simultaneous write and pop SHALL leave level unchanged.
REQ-020 FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE -> START when empty=0 and cts_s=0; in that cycle the head byte is popped into the shift register and the active period (ds80-selected) is latched for the whole frame.
REQ-022 START, each DATA bit, and STOP SHALL each last exactly the latched period in cycles (243 or 208); frame = 10 periods.
REQ-023 tx SHALL be 0 in START, shift-register bit 0 in DATA (shift right after each bit, 8 bits), 1 in STOP and IDLE.
REQ-024 STOP -> START directly (no idle gap) when empty=0 and cts_s=0 on STOP's last cycle; otherwise STOP -> IDLE.
REQ-025 cts_s rising mid-frame SHALL NOT abort the frame; only the next frame start is held.
REQ-026 ds80 changes mid-frame SHALL take effect at the next frame start only.
REQ-027 Latency: wr at cycle N into an empty FIFO, cts_s=0, idle -> tx falls at cycle N+2.
REQ-028 txbusy SHALL be 1 in START/DATA/STOP, 0 in IDLE.
REQ-029 Bit counter 3 bits; baud counter 8 bits, counts latched period-1 down to 0, wraps to reload.

Reset
REQ-030 Reset SHALL force state=IDLE, tx=1, txbusy=0, FIFO empty (level=0, empty=1, full=0), overflow=0, synchronizer flops=0.
REQ-031 Reset mid-frame SHALL drive tx=1 the next cycle and discard the frame and FIFO contents; wr concurrent with reset SHALL be ignored.

Structure
REQ-032 Shared package uart_pkg SHALL hold CLK, CLKDS80, BPS, PERIOD, PERIODDS80 and the 2-bit FSM state encoding, for reuse by the existing receiver.
REQ-033 FIFO SHALL be one sub-module, uart_fifo (synchronous DEPTH x 8, wr/rd/level/full/empty); FSM, synchronizer and baud logic stay in uart_tx_flow.

Verification
REQ-034 ds80=0, write 0x55 -> tx low 243 cycles, then bits 1,0,1,0,1,0,1,0 at 243 cycles each, high 243; txbusy high 2430 cycles.
REQ-035 ds80=1, write 0xA3 then 0x0F back-to-back -> two frames of 2080 cycles each, no idle gap, bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
REQ-036 cts=1, write 0x41 -> tx stays 1, level=1; drop cts -> tx falls exactly 3 cycles after cts deasserts.
REQ-037 cts=1, 17 writes 0x00..0x10 -> full=1, level=16, overflow=1; release cts -> bytes 0x00..0x0F transmitted, 0x10 absent.
REQ-038 Assert cts mid-frame of 0x11 with 0x22 queued -> 0x11 completes, 0x22 held until cts drops.
REQ-039 Reset at DATA bit 3 of 0x7E -> tx=1 next cycle, txbusy=0, level=0, no further start bit.
